// File: rtl/branch_predictor_if.sv
// Fetch/EX signal bundle between the pipeline (master) and the branch predictor (slave).
interface branch_predictor_if #(
  parameter int unsigned PC_W = 32
);
  logic            if_valid;
  logic [PC_W-1:0] if_pc;
  logic            pred_taken;
  logic            ex_valid;
  logic [PC_W-1:0] ex_pc;
  logic            ex_pred_taken;
  logic            branch_hazard;
  logic            mispredict;
  logic            redirect_taken;
  logic [31:0]     branch_count;
  logic [31:0]     mispredict_count;

  modport master (
    output if_valid, if_pc, ex_valid, ex_pc, ex_pred_taken, branch_hazard,
    input  pred_taken, mispredict, redirect_taken, branch_count, mispredict_count
  );

  modport slave (
    input  if_valid, if_pc, ex_valid, ex_pc, ex_pred_taken, branch_hazard,
    output pred_taken, mispredict, redirect_taken, branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_predictor.sv
// PC-indexed table of 2-bit saturating counters; predicts at fetch, trains and flags mispredicts
// at EX. Define BRANCH_STATS_EN to add resolved-branch and misprediction counters.
module branch_predictor #(
  parameter int unsigned IDX_W = 6,
  parameter int unsigned PC_W  = 32
) (
  input logic              clk,
  input logic              reset,
  branch_predictor_if.slave bp
);
  localparam int unsigned Entries = 1 << IDX_W;

  logic [1:0]       table_q [Entries];
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic [1:0]       ex_cur;
  logic [1:0]       ex_next;

  assign if_idx = bp.if_pc[IDX_W+1:2];
  assign ex_idx = bp.ex_pc[IDX_W+1:2];

  // Word-aligned PCs: the byte offset and the bits above the index carry no information here.
  logic unused_pc;
  assign unused_pc = ^{bp.if_pc[PC_W-1:IDX_W+2], bp.if_pc[1:0],
                       bp.ex_pc[PC_W-1:IDX_W+2], bp.ex_pc[1:0]};

  // Reads the registered table only, so a same-cycle update is not bypassed.
  assign bp.pred_taken     = bp.if_valid & table_q[if_idx][1];
  assign bp.mispredict     = bp.ex_valid & (bp.branch_hazard != bp.ex_pred_taken);
  assign bp.redirect_taken = bp.ex_valid & bp.branch_hazard;

  always_comb begin
    ex_cur  = table_q[ex_idx];
    ex_next = ex_cur;
    if (bp.branch_hazard) begin
      if (ex_cur != 2'b11) ex_next = ex_cur + 2'b01;
    end else begin
      if (ex_cur != 2'b00) ex_next = ex_cur - 2'b01;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < Entries; i++) table_q[i] <= 2'b01;
    end else if (bp.ex_valid) begin
      table_q[ex_idx] <= ex_next;
    end
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] branch_count_q;
  logic [31:0] mispredict_count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      if (bp.ex_valid)   branch_count_q     <= branch_count_q + 32'd1;
      if (bp.mispredict) mispredict_count_q <= mispredict_count_q + 32'd1;
    end
  end

  assign bp.branch_count     = branch_count_q;
  assign bp.mispredict_count = mispredict_count_q;
`else
  assign bp.branch_count     = '0;
  assign bp.mispredict_count = '0;
`endif

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor paired with the EX-stage branch comparator. It predicts taken/not-taken at fetch from a table of 2-bit saturating counters indexed by PC. When a branch resolves in EX, it checks the comparator's actual outcome (`branch_hazard`) against the prediction carried down the pipeline. It flags mispredictions to the hazard/flush logic and trains the table.

## Interface
Parameters:
- `IDX_W`, default 6: table index width; the table holds 2^`IDX_W` entries, indexed by PC[`IDX_W`+1:2].
- `PC_W`, default 32: PC width.

Ports:
- `clk`, in, 1: clock; all state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `if_valid`, in, 1: fetch stage holds a valid instruction.
- `if_pc`, in, `PC_W`: fetch PC.
- `pred_taken`, out, 1: prediction for `if_pc`. Combinational; 0 when `if_valid`=0.
- `ex_valid`, in, 1: a conditional branch (beq/bne/bgtz/blez) is resolving in EX this cycle.
- `ex_pc`, in, `PC_W`: PC of the resolving branch.
- `ex_pred_taken`, in, 1: `pred_taken` value recorded at that branch's fetch.
- `branch_hazard`, in, 1: actual outcome from the comparator; 1 = taken.
- `mispredict`, out, 1: combinational; `ex_valid & (branch_hazard != ex_pred_taken)`.
- `redirect_taken`, out, 1: valid only when `mispredict`=1. 1 = redirect to the branch target; 0 = redirect to `ex_pc`+4. Equals `branch_hazard`.
- `branch_count`, out, 32: resolved-branch counter; tied to 0 without `BRANCH_STATS_EN`.
- `mispredict_count`, out, 32: misprediction counter; tied to 0 without `BRANCH_STATS_EN`.

## Operation
- Table: 2^`IDX_W` entries of 2-bit counters. Encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
- Prediction: `pred_taken` = MSB of entry[`if_pc`[`IDX_W`+1:2]] & `if_valid`. PC bits [1:0] are ignored.
- Update: at a rising edge with `ex_valid`=1, entry[`ex_pc`[`IDX_W`+1:2]] changes as follows:
  - `branch_hazard`=1: +1, saturating at 11.
  - `branch_hazard`=0: −1, saturating at 00.
  - `ex_valid`=0: no entry changes.
- Aliasing: PCs sharing index bits share one entry. No tags.
- Read/update collision (same index at fetch and EX in one cycle): `pred_taken` reflects the pre-update value. No bypass.
- `mispredict` and `redirect_taken` do not depend on table state. The pipeline owns flush and PC muxing; this block only reports.
- `pred_taken` reads only table state, so `mispredict` cannot loop combinationally back to `pred_taken`.

## Timing
- Reset (asynchronous, takes effect immediately):
  - All entries = 01.
  - `pred_taken`=0.
  - `branch_count`=`mispredict_count`=0.
  - `mispredict`=0 and `redirect_taken`=0 as long as `ex_valid`=0.
- Prediction latency: 0 cycles, combinational from `if_pc`.
- Training latency: an update in cycle N is visible to `pred_taken` from cycle N+1.
- Reset asserted mid-operation: the table reinitialises to 01 regardless of `ex_valid`. An update pending at that edge is discarded.
- Back-to-back resolutions of the same index apply once per cycle, in order. Example: 01 with taken, then taken → 10 → 11.

## Configuration
- Macro: `BRANCH_STATS_EN`.
- Defined:
  - `branch_count` increments on every edge with `ex_valid`=1.
  - `mispredict_count` increments on every edge with `mispredict`=1.
  - Both are 32-bit, wrap from 0xFFFFFFFF to 0, and are cleared by `reset`.
- Undefined: both outputs are constant 0 and no counter flops are synthesised. Prediction behaviour is identical either way.

## Test plan
- Reset, then `if_valid`=1 with `if_pc`=0x00400000 → `pred_taken`=0. Every index reads weak NT.
- `ex_pc`=0x00400010, `ex_pred_taken`=0, `branch_hazard`=1, `ex_valid`=1 → `mispredict`=1 and `redirect_taken`=1 that cycle. Next cycle, `if_pc`=0x00400010 → `pred_taken`=1.
- Saturation: train index 4 taken three times, then not-taken once → `pred_taken` stays 1 (11→10). A second not-taken → `pred_taken`=0 (01).
- Collision: same index at IF and EX in one cycle, entry 01, taken update → `pred_taken`=0 that cycle and 1 the next.
- Aliasing: `IDX_W`=6; training 0x00000004 taken twice → `pred_taken`=1 at `if_pc`=0x00000104.
- With `BRANCH_STATS_EN`: 10 resolutions, 3 of them mispredicted → `branch_count`=10 and `mispredict_count`=3. Then assert `reset` mid-stream → both read 0 immediately. Without the macro, both read 0 throughout.
